order_ctrl: RTL and testbench
=============================

# order_ctrl

Order/payment front end for the coffee machine: accepts debounced coin and button presses, keeps a credit balance, and starts a brew cycle only once the price is covered. Holds the machine's enable for the whole cycle and hands any change back through a valid/ack handshake. Sits directly upstream of the coffee machine FSM. Its `brew_en` drives that block's `en`, and it consumes the machine's end-of-cycle indication as `brew_done`.

## Interface
- `PRICE`, 15: credit units charged per brew.
- `MAX_CREDIT`, 99: credit ceiling, two SSD digits.
- `DEBOUNCE_CYCLES`, 1000000: stable-input cycles required per button (10 ms at 100 MHz).
- `TIMEOUT_CYCLES`, 3000000000: idle-credit timeout. Used only with the timeout macro.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `btn_coin5`, `btn_coin10`, `btn_order`, `btn_cancel` in 1 each: raw push buttons.
- `brew_done` in 1: level from the coffee machine, high when a cycle completes. Rising edge used.
- `change_ack` in 1: change dispensed.
- `brew_en` out 1: enable to the coffee machine.
- `credit` out 7: current balance, 0..MAX_CREDIT.
- `change` out 7: change owed.
- `change_valid` out 1: `change` is valid.
- `coin_reject` out 1: one-cycle pulse.
- `low_credit` out 1: one-cycle pulse.
- `state_led` out 4: one-hot state. bit0 IDLE, bit1 CREDIT, bit2 BREWING, bit3 CHANGE.

## Operation
- Each button passes through a conditioner: 2-FF synchroniser, then stable-count debounce, then a registered rising-edge detector. The result is one single-cycle pulse per press.
- `brew_done` is rising-edge detected internally. A long level counts once.
- **IDLE**
  - Coin pulse: add value (5 or 10) and go to CREDIT.
  - Order and cancel are ignored.
- **CREDIT**, priority cancel > order > coin:
  - Cancel: `change` <= `credit`, `credit` <= 0, go to CHANGE.
  - Order with `credit` >= `PRICE`: `change` <= `credit - PRICE`, `credit` <= 0, `brew_en` <= 1, go to BREWING.
  - Order with `credit` < `PRICE`: pulse `low_credit` and stay.
  - Any coin in the same cycle as a cancel or order: rejected, `coin_reject` pulses.
  - Coins alone: add their sum. Both coins in one cycle add 15.
  - If the sum would exceed `MAX_CREDIT`: the whole cycle's coins are rejected, `credit` is unchanged, `coin_reject` pulses.
- **BREWING**
  - `brew_en` = 1.
  - Coins are rejected with `coin_reject`.
  - Order and cancel are ignored.
  - `brew_done` edge: `brew_en` <= 0. Go to CHANGE if `change` != 0, else IDLE.
- **CHANGE**
  - `change_valid` = 1 and `change` is held stable.
  - `change_ack`: `change` <= 0, `change_valid` <= 0, go to IDLE.
  - Coins are rejected. Order and cancel are ignored.
- Arithmetic: unsigned, 7-bit. The compare against `MAX_CREDIT` uses an 8-bit sum, so no wrap-around.

## Timing
- All outputs are registered.
- Reset values:
  - `brew_en`, `credit`, `change`, `change_valid`, `coin_reject`, `low_credit` = 0.
  - `state_led` = 4'b0001.
  - Debounce counters and synchronisers cleared.
- Reset mid-operation aborts everything at once: `brew_en` drops on the next edge and owed change is lost.
- Raw press to conditioned pulse: exactly `DEBOUNCE_CYCLES` + 3 clk cycles when the input stays stable.
- Conditioned pulse to output update (`credit`, state, `brew_en`, `coin_reject`, `low_credit`): 1 cycle.
- `brew_done` rising edge to `brew_en` low: 2 cycles (edge register, then state register).
- `change_ack` asserted with `change_valid` high: IDLE on the next edge. `change_ack` while `change_valid` is low is ignored.

## Configuration
- `ORDER_CTRL_TIMEOUT_EN` defined:
  - A timer counts cycles in CREDIT and resets on any accepted coin or rejected order.
  - Reaching `TIMEOUT_CYCLES` behaves exactly as a cancel: refund to CHANGE.
  - Cancel, order and coins take priority over the timeout in the same cycle.
- Macro undefined: no timer. CREDIT persists indefinitely.

## Structure
- Package `order_ctrl_pkg`:
  - State enum (IDLE, CREDIT, BREWING, CHANGE).
  - Coin value constants `COIN_SMALL`=5 and `COIN_LARGE`=10.
  - Credit width constant 7.
- Sub-module `button_conditioner`: synchroniser, debounce counter and edge pulse, parameterised by `DEBOUNCE_CYCLES`. Instantiated four times.

## Test plan
Benches run with `DEBOUNCE_CYCLES`=2 and, when the macro is on, `TIMEOUT_CYCLES`=50.
- **Coin then brew:** coin10, coin10, order.
  - `credit` 10 → 20.
  - Then `brew_en`=1, `credit`=0, `change`=5, `state_led`=0100.
  - `brew_done` edge: CHANGE with `change_valid`=1. `change_ack`: IDLE, `change`=0.
- **Low credit:** coin5, order → `low_credit` pulse, stays in CREDIT with `credit`=5. A second coin10 plus order → BREWING with `change`=0. `brew_done` → IDLE directly.
- **Saturation:** coins to 95, then coin10 → `coin_reject`, `credit` stays 95. Coin5 then coin10 together at 90 → rejected, `credit` stays 90.
- **Simultaneous:** at 15, order and coin5 in the same cycle → BREWING, `coin_reject` pulse, `change`=0. Cancel and order together at 20 → CHANGE with `change`=20.
- **Reset mid-brew and level `brew_done`:**
  - Assert `reset` in BREWING → next edge all outputs at reset values, `state_led`=0001.
  - Separately, hold `brew_done` high for 10 cycles → counts once.
- **Timeout (macro on):** coin5, then 50 idle cycles → CHANGE with `change`=5. With the macro off, still in CREDIT after 200 cycles.

Source files
------------

// File: rtl/order_ctrl_pkg.sv
// Shared types and constants for the coffee-machine order/payment front end.
package order_ctrl_pkg;

   localparam int CREDIT_W = 7;

   localparam logic [CREDIT_W-1:0] COIN_SMALL = 7'd5;
   localparam logic [CREDIT_W-1:0] COIN_LARGE = 7'd10;

   // One-hot encoding so the state register drives the LEDs directly.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_CREDIT  = 4'b0010,
      ST_BREWING = 4'b0100,
      ST_CHANGE  = 4'b1000
   } state_t;

endpackage

// File: rtl/order_ctrl_button_conditioner.sv
// Raw push button to single-cycle press pulse: 2-FF synchroniser, stable-count
// debounce, registered rising-edge detector.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic          r_stable_d;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_pulse    <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync1    <= i_btn;
         r_sync2    <= r_sync1;
         r_stable_d <= r_stable;
         r_pulse    <= r_stable & ~r_stable_d;
         // Any glitch back to the accepted level restarts the stability count.
         if (r_sync2 != r_stable) begin
            if (r_cnt == CNT_LAST) begin
               r_stable <= r_sync2;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/order_ctrl.sv
// Order/payment front end: credit accounting, brew enable and change handshake.
// Optional idle-credit refund timer enabled by defining ORDER_CTRL_TIMEOUT_EN.
module order_ctrl
   import order_ctrl_pkg::*;
#(
   parameter int          PRICE           = 15,
   parameter int          MAX_CREDIT      = 99,
   parameter int          DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned TIMEOUT_CYCLES  = 32'd3000000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn_coin5,
   input  logic                btn_coin10,
   input  logic                btn_order,
   input  logic                btn_cancel,
   input  logic                brew_done,
   input  logic                change_ack,
   output logic                brew_en,
   output logic [CREDIT_W-1:0] credit,
   output logic [CREDIT_W-1:0] change,
   output logic                change_valid,
   output logic                coin_reject,
   output logic                low_credit,
   output logic [3:0]          state_led
);

   localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W + 1)'(MAX_CREDIT);

   logic [3:0] w_raw;
   logic [3:0] w_pulse;
   logic       w_coin5;
   logic       w_coin10;
   logic       w_order;
   logic       w_cancel;
   logic       w_any_coin;
   logic [7:0] w_sum;
   logic       w_timeout;

   state_t              r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] r_change;
   logic                r_brew_en;
   logic                r_change_valid;
   logic                r_coin_reject;
   logic                r_low_credit;
   logic                r_done_prev;
   logic                r_done_edge;

   assign w_raw = {btn_cancel, btn_order, btn_coin10, btn_coin5};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
         button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_cond (
            .clk    (clk),
            .reset  (reset),
            .i_btn  (w_raw[gi]),
            .o_pulse(w_pulse[gi])
         );
      end
   endgenerate

   assign w_coin5    = w_pulse[0];
   assign w_coin10   = w_pulse[1];
   assign w_order    = w_pulse[2];
   assign w_cancel   = w_pulse[3];
   assign w_any_coin = w_coin5 | w_coin10;
   // Eight-bit sum so the ceiling compare never sees a wrapped value.
   assign w_sum = {1'b0, r_credit}
                + (w_coin5  ? {1'b0, COIN_SMALL} : 8'd0)
                + (w_coin10 ? {1'b0, COIN_LARGE} : 8'd0);

`ifdef ORDER_CTRL_TIMEOUT_EN
   logic [31:0] r_timer;
   logic        w_coin_accept;
   logic        w_order_reject;

   assign w_coin_accept  = (r_state == ST_CREDIT) && !w_cancel && !w_order
                           && w_any_coin && (w_sum <= MAX_W);
   assign w_order_reject = (r_state == ST_CREDIT) && !w_cancel && w_order
                           && (r_credit < PRICE_W);
   assign w_timeout      = (r_state == ST_CREDIT) && (r_timer >= TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (reset || r_state != ST_CREDIT || w_coin_accept || w_order_reject || w_timeout) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_done_prev <= 1'b0;
         r_done_edge <= 1'b0;
      end else begin
         r_done_prev <= brew_done;
         r_done_edge <= brew_done & ~r_done_prev;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_credit       <= '0;
         r_change       <= '0;
         r_brew_en      <= 1'b0;
         r_change_valid <= 1'b0;
         r_coin_reject  <= 1'b0;
         r_low_credit   <= 1'b0;
      end else begin
         r_coin_reject <= 1'b0;
         r_low_credit  <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_any_coin) begin
                  r_credit <= w_sum[CREDIT_W-1:0];
                  r_state  <= ST_CREDIT;
               end
            end
            ST_CREDIT: begin
               // A timeout is only a fallback refund when nothing was pressed.
               if (w_cancel || (!w_order && !w_any_coin && w_timeout)) begin
                  r_change       <= r_credit;
                  r_credit       <= '0;
                  r_change_valid <= 1'b1;
                  r_coin_reject  <= w_any_coin;
                  r_state        <= ST_CHANGE;
               end else if (w_order) begin
                  r_coin_reject <= w_any_coin;
                  if (r_credit >= PRICE_W) begin
                     r_change  <= r_credit - PRICE_W;
                     r_credit  <= '0;
                     r_brew_en <= 1'b1;
                     r_state   <= ST_BREWING;
                  end else begin
                     r_low_credit <= 1'b1;
                  end
               end else if (w_any_coin) begin
                  if (w_sum > MAX_W) begin
                     r_coin_reject <= 1'b1;
                  end else begin
                     r_credit <= w_sum[CREDIT_W-1:0];
                  end
               end
            end
            ST_BREWING: begin
               r_coin_reject <= w_any_coin;
               if (r_done_edge) begin
                  r_brew_en <= 1'b0;
                  if (r_change != '0) begin
                     r_change_valid <= 1'b1;
                     r_state        <= ST_CHANGE;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_CHANGE: begin
               r_coin_reject <= w_any_coin;
               if (change_ack && r_change_valid) begin
                  r_change       <= '0;
                  r_change_valid <= 1'b0;
                  r_state        <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign brew_en      = r_brew_en;
   assign credit       = r_credit;
   assign change       = r_change;
   assign change_valid = r_change_valid;
   assign coin_reject  = r_coin_reject;
   assign low_credit   = r_low_credit;
   assign state_led    = r_state;

endmodule

// File: tb/tb_order_ctrl.sv
// Directed bench for order_ctrl with DEBOUNCE_CYCLES=2 and TIMEOUT_CYCLES=50.
// Exercises the ORDER_CTRL_TIMEOUT_EN branch matching the build's define.
module tb_order_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_coin5 = 1'b0, btn_coin10 = 1'b0, btn_order = 1'b0, btn_cancel = 1'b0;
   logic       brew_done = 1'b0, change_ack = 1'b0;
   logic       brew_en, change_valid, coin_reject, low_credit;
   logic [6:0] credit, change;
   logic [3:0] state_led;

   int checks = 0;
   int errors = 0;

   logic [6:0] pre_credit, snap_credit, snap_change;
   logic [3:0] snap_led;
   logic       snap_reject, snap_low, snap_brew;

   localparam logic [3:0] L_IDLE = 4'b0001, L_CREDIT = 4'b0010,
                          L_BREW = 4'b0100, L_CHANGE = 4'b1000;

   order_ctrl #(
      .PRICE(15), .MAX_CREDIT(99), .DEBOUNCE_CYCLES(2), .TIMEOUT_CYCLES(50)
   ) dut (
      .clk(clk), .reset(reset),
      .btn_coin5(btn_coin5), .btn_coin10(btn_coin10),
      .btn_order(btn_order), .btn_cancel(btn_cancel),
      .brew_done(brew_done), .change_ack(change_ack),
      .brew_en(brew_en), .credit(credit), .change(change),
      .change_valid(change_valid), .coin_reject(coin_reject),
      .low_credit(low_credit), .state_led(state_led)
   );

   always #5 clk = ~clk;

   // Press buttons; the FSM reacts exactly DEBOUNCE_CYCLES+4 edges after the press.
   task automatic press(input logic c5, input logic c10, input logic ord, input logic can);
      btn_coin5 = c5; btn_coin10 = c10; btn_order = ord; btn_cancel = can;
      repeat (5) @(posedge clk);
      #1 pre_credit = credit;
      @(posedge clk);
      #1;
      snap_credit = credit; snap_change = change; snap_led = state_led;
      snap_reject = coin_reject; snap_low = low_credit; snap_brew = brew_en;
      btn_coin5 = 0; btn_coin10 = 0; btn_order = 0; btn_cancel = 0;
      repeat (8) @(posedge clk);
      #1;
      $display("press c5=%0b c10=%0b ord=%0b can=%0b -> credit=%0d change=%0d led=%b rej=%0b low=%0b",
               c5, c10, ord, can, snap_credit, snap_change, snap_led, snap_reject, snap_low);
   endtask

   task automatic ack_change();
      change_ack = 1'b1;
      @(posedge clk);
      #1 change_ack = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (state_led !== L_IDLE) begin errors++; $display("FAIL reset_led: got %b expected %b", state_led, L_IDLE); end
      checks++; if ({brew_en, change_valid, coin_reject, low_credit} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {brew_en, change_valid, coin_reject, low_credit}); end
      checks++; if (credit !== 7'd0 || change !== 7'd0) begin errors++; $display("FAIL reset_values: got credit=%0d change=%0d expected 0 0", credit, change); end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_coin_brew();
      change_ack = 1'b1;   // ack with no change pending must be ignored
      @(posedge clk);
      #1 change_ack = 1'b0;
      checks++; if (state_led !== L_IDLE) begin errors++; $display("FAIL stray_ack: got %b expected %b", state_led, L_IDLE); end
      press(0, 1, 0, 0);
      checks++; if (snap_credit !== 7'd10 || snap_led !== L_CREDIT) begin errors++; $display("FAIL coin10_first: got credit=%0d led=%b expected 10 0010", snap_credit, snap_led); end
      press(0, 1, 0, 0);
      checks++; if (pre_credit !== 7'd10) begin errors++; $display("FAIL latency_early: got credit=%0d expected 10", pre_credit); end
      checks++; if (snap_credit !== 7'd20) begin errors++; $display("FAIL coin10_second: got %0d expected 20", snap_credit); end
      press(0, 0, 1, 0);
      checks++; if (snap_brew !== 1'b1 || snap_credit !== 7'd0 || snap_change !== 7'd5 || snap_led !== L_BREW) begin errors++; $display("FAIL order_brew: got en=%0b credit=%0d change=%0d led=%b expected 1 0 5 0100", snap_brew, snap_credit, snap_change, snap_led); end
      brew_done = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (brew_en !== 1'b1) begin errors++; $display("FAIL done_latency1: got %0b expected 1", brew_en); end
      @(posedge clk);
      #1;
      checks++; if (brew_en !== 1'b0 || state_led !== L_CHANGE || change_valid !== 1'b1 || change !== 7'd5) begin errors++; $display("FAIL done_change: got en=%0b led=%b valid=%0b change=%0d expected 0 1000 1 5", brew_en, state_led, change_valid, change); end
      brew_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (change !== 7'd5 || change_valid !== 1'b1) begin errors++; $display("FAIL change_hold: got change=%0d valid=%0b expected 5 1", change, change_valid); end
      ack_change();
      checks++; if (state_led !== L_IDLE || change !== 7'd0 || change_valid !== 1'b0) begin errors++; $display("FAIL ack_idle: got led=%b change=%0d valid=%0b expected 0001 0 0", state_led, change, change_valid); end
   endtask

   task automatic test_low_credit();
      press(1, 0, 0, 0);
      press(0, 0, 1, 0);
      checks++; if (snap_low !== 1'b1 || snap_led !== L_CREDIT || snap_credit !== 7'd5) begin errors++; $display("FAIL low_credit: got low=%0b led=%b credit=%0d expected 1 0010 5", snap_low, snap_led, snap_credit); end
      checks++; if (low_credit !== 1'b0) begin errors++; $display("FAIL low_credit_pulse: got %0b expected 0", low_credit); end
      press(0, 1, 0, 0);
      press(0, 0, 1, 0);
      checks++; if (snap_led !== L_BREW || snap_change !== 7'd0 || snap_brew !== 1'b1) begin errors++; $display("FAIL exact_price: got led=%b change=%0d en=%0b expected 0100 0 1", snap_led, snap_change, snap_brew); end
      brew_done = 1'b1;
      repeat (2) @(posedge clk);
      #1 brew_done = 1'b0;
      checks++; if (state_led !== L_IDLE || brew_en !== 1'b0 || change_valid !== 1'b0) begin errors++; $display("FAIL done_no_change: got led=%b en=%0b valid=%0b expected 0001 0 0", state_led, brew_en, change_valid); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 9; i++) press(0, 1, 0, 0);
      checks++; if (credit !== 7'd90) begin errors++; $display("FAIL fill_90: got %0d expected 90", credit); end
      press(1, 1, 0, 0);
      checks++; if (snap_reject !== 1'b1 || snap_credit !== 7'd90) begin errors++; $display("FAIL both_at_90: got rej=%0b credit=%0d expected 1 90", snap_reject, snap_credit); end
      press(1, 0, 0, 0);
      checks++; if (snap_reject !== 1'b0 || snap_credit !== 7'd95) begin errors++; $display("FAIL coin5_to_95: got rej=%0b credit=%0d expected 0 95", snap_reject, snap_credit); end
      press(0, 1, 0, 0);
      checks++; if (snap_reject !== 1'b1 || snap_credit !== 7'd95) begin errors++; $display("FAIL coin10_at_95: got rej=%0b credit=%0d expected 1 95", snap_reject, snap_credit); end
      press(0, 0, 0, 1);
      checks++; if (snap_led !== L_CHANGE || snap_change !== 7'd95 || snap_credit !== 7'd0) begin errors++; $display("FAIL cancel_95: got led=%b change=%0d credit=%0d expected 1000 95 0", snap_led, snap_change, snap_credit); end
      ack_change();
   endtask

   task automatic test_simultaneous();
      press(1, 1, 0, 0);
      checks++; if (snap_credit !== 7'd15 || snap_led !== L_CREDIT) begin errors++; $display("FAIL both_from_idle: got credit=%0d led=%b expected 15 0010", snap_credit, snap_led); end
      press(1, 0, 1, 0);
      checks++; if (snap_led !== L_BREW || snap_reject !== 1'b1 || snap_change !== 7'd0) begin errors++; $display("FAIL order_plus_coin: got led=%b rej=%0b change=%0d expected 0100 1 0", snap_led, snap_reject, snap_change); end
      press(0, 1, 0, 0);
      checks++; if (snap_reject !== 1'b1 || snap_led !== L_BREW) begin errors++; $display("FAIL coin_in_brew: got rej=%0b led=%b expected 1 0100", snap_reject, snap_led); end
      brew_done = 1'b1;
      repeat (2) @(posedge clk);
      #1 brew_done = 1'b0;
      press(0, 1, 0, 0);
      press(0, 1, 0, 0);
      press(0, 0, 1, 1);
      checks++; if (snap_led !== L_CHANGE || snap_change !== 7'd20 || snap_brew !== 1'b0) begin errors++; $display("FAIL cancel_beats_order: got led=%b change=%0d en=%0b expected 1000 20 0", snap_led, snap_change, snap_brew); end
      ack_change();
   endtask

   task automatic test_reset_mid_brew();
      press(0, 1, 0, 0);
      press(0, 1, 0, 0);
      press(0, 0, 1, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (brew_en !== 1'b0 || state_led !== L_IDLE || change !== 7'd0 || credit !== 7'd0 || change_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_brew: got en=%0b led=%b change=%0d credit=%0d valid=%0b expected 0 0001 0 0 0", brew_en, state_led, change, credit, change_valid); end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_level_done();
      press(0, 1, 0, 0);
      press(0, 1, 0, 0);
      press(0, 0, 1, 0);
      brew_done = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (state_led !== L_CHANGE || change !== 7'd5) begin errors++; $display("FAIL level_done_end: got led=%b change=%0d expected 1000 5", state_led, change); end
      ack_change();
      press(1, 0, 0, 0);
      press(0, 1, 0, 0);
      press(0, 0, 1, 0);
      repeat (10) @(posedge clk);
      #1;
      checks++; if (state_led !== L_BREW || brew_en !== 1'b1) begin errors++; $display("FAIL level_done_once: got led=%b en=%0b expected 0100 1", state_led, brew_en); end
      brew_done = 1'b0;
      @(posedge clk);
      #1 brew_done = 1'b1;
      repeat (2) @(posedge clk);
      #1 brew_done = 1'b0;
      checks++; if (state_led !== L_IDLE) begin errors++; $display("FAIL level_done_new_edge: got %b expected %b", state_led, L_IDLE); end
   endtask

   task automatic test_timeout();
      press(1, 0, 0, 0);
`ifdef ORDER_CTRL_TIMEOUT_EN
      repeat (60) @(posedge clk);
      #1;
      checks++; if (state_led !== L_CHANGE || change !== 7'd5 || credit !== 7'd0) begin errors++; $display("FAIL timeout_refund: got led=%b change=%0d credit=%0d expected 1000 5 0", state_led, change, credit); end
      ack_change();
`else
      repeat (200) @(posedge clk);
      #1;
      checks++; if (state_led !== L_CREDIT || credit !== 7'd5) begin errors++; $display("FAIL no_timeout: got led=%b credit=%0d expected 0010 5", state_led, credit); end
      press(0, 0, 0, 1);
      ack_change();
`endif
      checks++; if (state_led !== L_IDLE) begin errors++; $display("FAIL timeout_cleanup: got %b expected %b", state_led, L_IDLE); end
   endtask

   initial begin
      test_reset();
      test_coin_brew();
      test_low_credit();
      test_saturation();
      test_simultaneous();
      test_reset_mid_brew();
      test_level_done();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
